// File: rtl/rr_grant_scheduler_pkg.sv
// Shared constants and helpers for the round-robin grant scheduler.
// State encoding, default index width, pointer increment helper.
package rr_grant_scheduler_pkg;

  localparam int IN_DEF = 4;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  function automatic int unsigned next_idx(
    input int unsigned idx,
    input int unsigned in_w = IN_DEF
  );
    return (idx + 1) % (32'd1 << in_w);
  endfunction

endpackage

// File: rtl/decoder_param.sv
// Binary-to-one-hot decoder, IN-bit digit to 2**IN-bit vector.
// Ports: digit (binary in), vector (one-hot out).
module decoder_param #(
  parameter  int IN = 4,
  localparam int N  = 2**IN
) (
  input  logic [IN-1:0] digit,
  output logic [N-1:0]  vector
);

  always_comb begin
    vector = '0;
    vector[digit] = 1'b1;
  end

endmodule

// File: rtl/rr_grant_scheduler.sv
// Round-robin scheduler: one owner at a time, held until release.
// Ports: clk, rst_n, req, done in; grant, grant_idx, grant_valid out.
import rr_grant_scheduler_pkg::*;

module rr_grant_scheduler #(
  parameter  int IN = IN_DEF,
  localparam int N  = 2**IN
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          done,
  output logic [N-1:0]  grant,
  output logic [IN-1:0] grant_idx,
  output logic          grant_valid
);

  logic [0:0]    state;
  logic [0:0]    state_n;
  logic [IN-1:0] ptr;
  logic [IN-1:0] ptr_n;
  logic [IN-1:0] ptr_rel;
  logic [IN-1:0] idx_n;
  logic [N-1:0]  raw;
  logic [IN:0]   hit;
  logic [IN:0]   hand;
  logic          rel;

  // {found, index} of first set bit at or after s, wrapping.
  function automatic logic [IN:0] pick(
    input logic [N-1:0]  v,
    input logic [IN-1:0] s
  );
    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [IN:0]    r;
    dbl = {v, v};
    rot = dbl[s +: N];
    r   = '0;
    for (int i = N-1; i >= 0; i--) begin
      if (rot[i]) r = {1'b1, s + IN'(i)};
    end
    return r;
  endfunction

  decoder_param #(.IN(IN)) u_dec (
    .digit  (grant_idx),
    .vector (raw)
  );

  assign grant_valid = (state == BUSY);
  assign grant       = raw & {N{grant_valid}};

  // done and owner drop together are one release.
  assign rel     = grant_valid & (done | ~req[grant_idx]);
  assign ptr_rel = IN'(next_idx(32'(grant_idx), IN));
  assign hit     = pick(req, ptr);
  // Owner masked so a handoff never re-grants it.
  assign hand    = pick(req & ~raw, ptr_rel);

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    idx_n   = grant_idx;
    unique case (state)
      IDLE: begin
        if (hit[IN]) begin
          state_n = BUSY;
          idx_n   = hit[IN-1:0];
        end
      end
      BUSY: begin
        if (rel) begin
          ptr_n = ptr_rel;
          if (hand[IN]) begin
            idx_n = hand[IN-1:0];
          end else begin
            state_n = IDLE;
            idx_n   = '0;
          end
        end
      end
      default: begin
        state_n = IDLE;
        idx_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      grant_idx <= '0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      grant_idx <= idx_n;
    end
  end

endmodule

// File: tb/tb_rr_grant_scheduler.sv
// Scoreboard bench for rr_grant_scheduler.
// Directed stimulus, expectations queued, checked by a monitor.
module tb_rr_grant_scheduler;

  logic        clk;
  logic        rst_n;
  logic [15:0] req;
  logic        done;
  logic [15:0] grant;
  logic [3:0]  grant_idx;
  logic        grant_valid;

  typedef struct {
    int         cyc;
    logic       v;
    logic [3:0] idx;
  } exp_t;

  exp_t q[$];
  int   cyc;
  int   n_chk;
  int   n_fail;

  rr_grant_scheduler #(.IN(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .done        (done),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)",
               nm, act, exp, $time);
    end
  endtask

  task automatic chk_out(
    input string      nm,
    input logic       v,
    input logic [3:0] idx
  );
    logic [15:0] g;
    g = v ? (16'h1 << idx) : 16'h0;
    chk({nm, ".valid"}, 32'(grant_valid), 32'(v));
    chk({nm, ".idx"}, 32'(grant_idx), 32'(idx));
    chk({nm, ".grant"}, 32'(grant), 32'(g));
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      if (e.cyc < cyc) begin
        n_chk++;
        n_fail++;
        $display("FAIL stale: cyc %0d expected at %0d",
                 cyc, e.cyc);
      end else begin
        chk_out($sformatf("c%0d", e.cyc), e.v, e.idx);
      end
    end
  end

  // Apply inputs for one cycle; expect outputs after the edge.
  task automatic step(
    input logic [15:0] r,
    input logic        d,
    input logic        v,
    input logic [3:0]  idx
  );
    exp_t e;
    req  = r;
    done = d;
    e.cyc = cyc + 1;
    e.v   = v;
    e.idx = idx;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset(input logic [15:0] r);
    @(negedge clk);
    #1;
    req   = r;
    done  = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_out("async_rst", 1'b0, 4'd0);
    @(posedge clk);
    #1;
    chk_out("in_rst", 1'b0, 4'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    req    = '0;
    done   = 1'b0;
    #3;
    chk_out("reset", 1'b0, 4'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) step(16'h0000, 1'b0, 1'b0, 4'd0);

    // single requester, then ptr lands on 6
    step(16'h0020, 1'b0, 1'b1, 4'd5);
    step(16'h0020, 1'b1, 1'b0, 4'd0);
    step(16'h0041, 1'b0, 1'b1, 4'd6);
    step(16'h0000, 1'b0, 1'b0, 4'd0);

    pulse_reset(16'h0000);

    // full contention, walking grant with wrap
    step(16'hFFFF, 1'b0, 1'b1, 4'd0);
    for (int i = 1; i <= 16; i++)
      step(16'hFFFF, 1'b1, 1'b1, 4'(i));
    for (int i = 1; i <= 14; i++)
      step(16'hFFFF, 1'b1, 1'b1, 4'(i));

    // wrap between 15 and 0
    step(16'h8001, 1'b1, 1'b1, 4'd15);
    step(16'h8001, 1'b1, 1'b1, 4'd0);
    step(16'h8001, 1'b1, 1'b1, 4'd15);
    // done plus owner drop: one release, to idle
    step(16'h0000, 1'b1, 1'b0, 4'd0);

    // owner 3, others ignored, then abandon
    step(16'h0008, 1'b0, 1'b1, 4'd3);
    step(16'h0008, 1'b0, 1'b1, 4'd3);
    step(16'hFFFF, 1'b0, 1'b1, 4'd3);
    step(16'h0100, 1'b0, 1'b1, 4'd8);
    step(16'h0100, 1'b1, 1'b0, 4'd0);
    step(16'h0000, 1'b1, 1'b0, 4'd0);

    // reset while 9 owns the grant
    step(16'h0200, 1'b0, 1'b1, 4'd9);
    step(16'h0200, 1'b0, 1'b1, 4'd9);
    pulse_reset(16'h0600);
    step(16'h0600, 1'b0, 1'b1, 4'd9);
    step(16'h0600, 1'b1, 1'b1, 4'd10);

    for (int i = 0; i < 20 && q.size() > 0; i++)
      @(posedge clk);
    if (q.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_grant_scheduler.md
Name: rr_grant_scheduler

Overview:
- Round-robin scheduler that shares one resource among 2**IN requesters.
- The grant is held until the owner releases it.
- The grant index is registered in binary and expanded to a one-hot grant vector by the existing decoder_param block.
- Sits between requesting agents and a shared datapath or bus. It is the sequencing companion to decoder_param.

Parameters:
- IN, 4, width of the binary grant index.
- N, 2**IN, number of requesters (derived; do not override independently).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  N  per-requester request level; bit k = requester k.
- done  input  1  one-cycle release pulse from the current owner.
- grant  output  N  one-hot grant; all-zero when no owner.
- grant_idx  output  IN  binary index of the current owner; 0 when idle.
- grant_valid  output  1  high while any grant is held.

Behaviour:
- Reset (async, rst_n=0):
  - State=IDLE.
  - Pointer ptr=0.
  - grant_idx=0, grant_valid=0, grant=0 (gated by grant_valid).
- grant = decoder output of grant_idx, ANDed with grant_valid. This keeps grant exactly one-hot or zero; it is never one-hot on index 0 while idle.
- State machine, two states: IDLE and BUSY.
- IDLE:
  - If req != 0: select winner w = first set bit of req searching ptr, ptr+1, …, N-1, 0, …, ptr-1 (wrap modulo N).
  - Next edge: grant_idx=w, grant_valid=1, state=BUSY.
  - Latency from req to grant is 1 cycle.
- BUSY, release condition = done=1 OR req[grant_idx]=0 (owner abandon).
  - On release: ptr ← (grant_idx+1) mod N, wrapping N-1 → 0.
  - If req with the owner's bit masked is nonzero, pick the next winner from the new ptr in the same cycle. Next edge: new grant_idx, grant_valid stays 1, state stays BUSY. Back-to-back handoff has no idle bubble.
  - Otherwise: grant_valid=0, grant_idx=0, state=IDLE.
  - The owner's own req is masked in the handoff search, so one owner can never be granted twice in a row through a handoff. It may win again from IDLE later.
- BUSY, no release: all outputs hold. New requests from others are ignored until release.
- done while in IDLE is ignored.
- done and a simultaneous drop of the owner's req count as a single release.
- Fairness: with all N requesting continuously and done every cycle, each requester is granted exactly once per N grants, in ascending cyclic order.
- Reset asserted mid-ownership: outputs clear immediately (asynchronously) and ptr returns to 0. After deassertion the first grant follows the IDLE rule from ptr=0.
- All state is registered. The winner search is combinational, a priority search over a rotated vector of width N.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE=0, BUSY=1);
  - the default IN value;
  - a helper function next_idx(idx) = (idx+1) mod 2**IN.
- Sub-module: instantiate the existing decoder_param with parameter IN. digit = grant_idx (IN bits); vector = raw one-hot (N bits).
- The rotate/priority-search is written inline (function), not a separate module.

Test Plan:
- Reset, then req=16'h0000 for 5 cycles → grant=0, grant_valid=0, grant_idx=0 throughout.
- Single requester: req=16'h0020 → one cycle later grant_idx=5, grant=16'h0020. Then done pulse → next edge grant_valid=0 and ptr=6.
- Full contention: req=16'hFFFF, done=1 every BUSY cycle → grant_idx sequence 0,1,2,…,15,0 with no bubble. grant shows a walking one from 16'h0001 to 16'h8000.
- Wrap: ptr=15 (after granting 14), req=16'h8001 → 15 is granted first. After done, 0 is granted. Then after done with req still 16'h8001, 15 is granted.
- Owner abandon: grant_idx=3, req drops to 16'h0100 with no done → next edge grant_idx=8, grant=16'h0100.
- Reset mid-grant: grant_idx=9 held, rst_n pulled low between edges → grant=0 and grant_valid=0 with no clock edge. After release with req=16'h0600 → grant_idx=9? No: ptr=0, so winner is 9 only if bit 9 is set. With req=16'h0600 the winner is 9.
